// File: rtl/rom_loader.sv
// rom_loader -- HPS ioctl download loader for the cartridge and BIOS stores.
//
// Steers each downloaded byte into the BIOS or cart dual-port RAM according
// to ioctl_index. For cart loads it recognises a 7800-style header ("ATARI"
// at offsets 1..5), latches the header fields and relocates the payload to
// address 0. When the load finishes it reports the payload size. A single
// write buffer gives the memory side backpressure through ioctl_wait.
//
// Optional feature: define ROM_LOADER_CHECKSUM_EN to add the checksum output.
//
// Ports:
//   clk_sys, reset        system clock, synchronous active-high reset
//   ioctl_*               HPS download stream (download window, byte strobe,
//                         offset, data, target index) and ioctl_wait stall
//   mem_addr/mem_data     buffered store write address and data
//   mem_we_cart/_bios     store write request, held until mem_ack
//   mem_ack               store accepted the current write this cycle
//   is_7800, cart_*       header match flag, payload size, header fields
//   joy0_type, joy1_type  header bytes 55 and 56
//   load_done             one-cycle pulse at the end of each cart load
//   initial_pause         high from reset until the first cart load completes
//   checksum              (ROM_LOADER_CHECKSUM_EN) 16-bit payload byte sum
module rom_loader #(
  parameter int          ADDR_W      = 18,
  parameter int          BIOS_ADDR_W = 12,
  parameter int          BIOS_INDEX  = 0,
  parameter int          HDR_LEN     = 128,
  parameter logic [39:0] MAGIC       = 40'h4154415249
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic [7:0]        ioctl_index,
  output logic              ioctl_wait,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_we_cart,
  output logic              mem_we_bios,
  input  logic              mem_ack,
  output logic              is_7800,
  output logic [31:0]       cart_size,
  output logic [15:0]       cart_flags,
  output logic [7:0]        joy0_type,
  output logic [7:0]        joy1_type,
  output logic [7:0]        cart_region,
  output logic [7:0]        cart_save,
  output logic              load_done,
  output logic              initial_pause
`ifdef ROM_LOADER_CHECKSUM_EN
  ,
  output logic [15:0]       checksum
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, FINISH} state_t;

  state_t              state_q, state_d;
  logic                dl_q;        // ioctl_download delayed, for edge detect
  logic                cart_q;      // target of the current window
  logic                full_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          data_q;
  logic [39:0]         magic_q;
  logic [15:0]         flags_q;
  logic [7:0]          joy0_q, joy1_q, region_q, save_q;
  logic [24:0]         last_addr_q;
  logic                written_q;
  logic [31:0]         size_q;
  logic                pause_q;

  logic                start, accept, hdr_hit;
  logic [ADDR_W-1:0]   cart_addr, bios_addr;
  logic [31:0]         la1, size_calc;

  assign start   = (state_q == IDLE) && ioctl_download && !dl_q;
  // A strobe while the buffer is full is a protocol violation: dropped.
  assign accept  = (state_q == LOAD) && ioctl_wr && !full_q;
  assign hdr_hit = (magic_q == MAGIC);

  // Payload behind a matched header is relocated to 0; header bytes land raw
  // at 0..HDR_LEN-1 first and are overwritten by the payload later.
  assign cart_addr = (hdr_hit && (ioctl_addr >= 25'(HDR_LEN)))
                   ? ADDR_W'(ioctl_addr - 25'(HDR_LEN))
                   : ioctl_addr[ADDR_W-1:0];
  assign bios_addr = ADDR_W'(ioctl_addr[BIOS_ADDR_W-1:0]);

  assign la1 = 32'(last_addr_q) + 32'd1;
  always_comb begin
    size_calc = 32'd0;
    if (written_q) begin
      if (!hdr_hit)                   size_calc = la1;
      else if (la1 >= 32'(HDR_LEN))   size_calc = la1 - 32'(HDR_LEN);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (start) state_d = LOAD;
      LOAD:   if (!ioctl_download) state_d = DRAIN;
      // Leave as soon as the buffer is empty or empties on this cycle.
      DRAIN:  if (!full_q || mem_ack) state_d = FINISH;
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= IDLE;
      dl_q        <= 1'b0;
      cart_q      <= 1'b0;
      full_q      <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      magic_q     <= '0;
      flags_q     <= '0;
      joy0_q      <= '0;
      joy1_q      <= '0;
      region_q    <= '0;
      save_q      <= '0;
      last_addr_q <= '0;
      written_q   <= 1'b0;
      size_q      <= '0;
      pause_q     <= 1'b1;
    end else begin
      state_q <= state_d;
      dl_q    <= ioctl_download;

      if (start) begin
        cart_q      <= (ioctl_index != 8'(BIOS_INDEX));
        last_addr_q <= '0;
        written_q   <= 1'b0;
        // BIOS loads leave the cart header state untouched.
        if (ioctl_index != 8'(BIOS_INDEX)) begin
          magic_q  <= '0;
          flags_q  <= '0;
          joy0_q   <= '0;
          joy1_q   <= '0;
          region_q <= '0;
          save_q   <= '0;
        end
      end

      if (accept) begin
        full_q      <= 1'b1;
        data_q      <= ioctl_dout;
        addr_q      <= cart_q ? cart_addr : bios_addr;
        last_addr_q <= ioctl_addr;
        written_q   <= 1'b1;
        if (cart_q) begin
          if (ioctl_addr >= 25'd1 && ioctl_addr <= 25'd5)
            magic_q <= {magic_q[31:0], ioctl_dout};
          case (ioctl_addr)
            25'd53:  flags_q[15:8] <= ioctl_dout;
            25'd54:  flags_q[7:0]  <= ioctl_dout;
            25'd55:  joy0_q        <= ioctl_dout;
            25'd56:  joy1_q        <= ioctl_dout;
            25'd57:  region_q      <= ioctl_dout;
            25'd58:  save_q        <= ioctl_dout;
            default: ;
          endcase
        end
      end else if (full_q && mem_ack) begin
        full_q <= 1'b0;
      end

      if (state_q == FINISH && cart_q) begin
        size_q  <= size_calc;
        pause_q <= 1'b0;
      end
    end
  end

`ifdef ROM_LOADER_CHECKSUM_EN
  // Header membership is only known once the magic is in, so bytes below
  // HDR_LEN are summed separately and subtracted if the header matched.
  logic [15:0] sum_all_q, sum_hdr_q;
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sum_all_q <= '0;
      sum_hdr_q <= '0;
    end else if (start) begin
      sum_all_q <= '0;
      sum_hdr_q <= '0;
    end else if (accept && cart_q) begin
      sum_all_q <= sum_all_q + 16'(ioctl_dout);
      if (ioctl_addr < 25'(HDR_LEN)) sum_hdr_q <= sum_hdr_q + 16'(ioctl_dout);
    end
  end
  assign checksum = hdr_hit ? (sum_all_q - sum_hdr_q) : sum_all_q;
`endif

  // Write request and stall drop in the very cycle reset is sampled.
  assign ioctl_wait    = full_q & ~reset;
  assign mem_we_cart   = full_q &  cart_q & ~reset;
  assign mem_we_bios   = full_q & ~cart_q & ~reset;
  assign mem_addr      = addr_q;
  assign mem_data      = data_q;
  assign is_7800       = hdr_hit;
  assign cart_size     = size_q;
  assign cart_flags    = flags_q;
  assign joy0_type     = joy0_q;
  assign joy1_type     = joy1_q;
  assign cart_region   = region_q;
  assign cart_save     = save_q;
  assign load_done     = (state_q == FINISH) && cart_q;
  assign initial_pause = pause_q;

endmodule
